// File: rtl/dehaze_pkg.sv
// dehaze_pkg: pixel type, default frame geometry and sequencer state encoding
package dehaze_pkg;
  localparam int PIXEL_W = 24;
  localparam int DEF_ROW_SIZE = 512;
  localparam int DEF_IMG_ROWS = 512;
  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef enum logic [2:0] {IDLE, CLR, FILL, STREAM, FLUSH, DONE} state_e;
endpackage

// File: rtl/window_feed_sequencer_if.sv
// window_feed_sequencer_if: source stream, downstream ready and WindowGenerator link
interface window_feed_sequencer_if;
  import dehaze_pkg::*;
  pixel_t s_pixel, wg_pixel;
  logic s_valid, s_last, s_ready, m_ready, wg_valid, wg_rst, wg_out_valid, win_valid;
  modport master (
    output s_pixel, s_valid, s_last, m_ready, wg_out_valid,
    input  s_ready, wg_pixel, wg_valid, wg_rst, win_valid
  );
  modport slave (
    input  s_pixel, s_valid, s_last, m_ready, wg_out_valid,
    output s_ready, wg_pixel, wg_valid, wg_rst, win_valid
  );
endinterface

// File: rtl/pos_counter.sv
// pos_counter: column/row position of fed pixels with column wrap and end-of-row flag
module pos_counter #(
  parameter int COLS = 8,
  parameter int ROWS = 7,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic          col_end
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  always_comb begin
    col_end = col_q == CW'(COLS - 1);
    col_d = clr ? '0 : en ? (col_end ? '0 : col_q + 1'b1) : col_q;
    row_d = clr ? '0 : (en && col_end) ? row_q + 1'b1 : row_q;
    row = row_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
endmodule

// File: rtl/window_feed_sequencer.sv
// window_feed_sequencer: meters a pixel stream into the window generator, pads the tail rows
// and qualifies generator windows against pixels actually fed.
module window_feed_sequencer import dehaze_pkg::*; #(
  parameter int     ROW_SIZE   = DEF_ROW_SIZE,
  parameter int     IMG_ROWS   = DEF_IMG_ROWS,
  parameter int     FILL_ROWS  = 3,
  parameter int     FLUSH_ROWS = 1,
  parameter pixel_t PAD_PIXEL  = '0
) (
  input  logic r_clk,
  input  logic r_rst,
  input  logic start,
  window_feed_sequencer_if.slave io,
  output logic busy,
  output logic frame_done,
  output logic err_last
);
  localparam int ROWS = IMG_ROWS + FLUSH_ROWS;
  localparam int RW = $clog2(ROWS);
  localparam int EXP = (ROWS - FILL_ROWS) * ROW_SIZE;
  localparam int WW = $clog2(EXP + 1);
  state_e state_q, state_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic err_last_q, err_last_d, fed_d1_q, fed_d1_d;
  logic [RW-1:0] row;
  logic col_end, streaming, fed, xfer, row_hit;
  pos_counter #(.COLS(ROW_SIZE), .ROWS(ROWS)) u_pos (
    .clk(r_clk), .rst(r_rst), .clr(state_q == CLR), .en(fed), .row(row), .col_end(col_end)
  );
  always_comb begin
    streaming = state_q == FILL || state_q == STREAM;
    fed = io.m_ready & (streaming ? io.s_valid : state_q == FLUSH);
    xfer = streaming & io.m_ready & io.s_valid;
    io.s_ready = streaming & io.m_ready;
    io.wg_valid = fed;
    io.wg_pixel = streaming ? io.s_pixel : PAD_PIXEL;
    io.wg_rst = state_q == CLR;
    io.win_valid = io.wg_out_valid & fed_d1_q;
    frame_done = io.win_valid && win_cnt_q == WW'(EXP - 1);
    busy = state_q != IDLE && state_q != DONE;
    err_last = err_last_q;
    fed_d1_d = fed;
    win_cnt_d = state_q == CLR ? '0 : win_cnt_q + WW'(io.win_valid);
    // s_last is only audited; the frame always ends on the internal position
    err_last_d = state_q == CLR ? 1'b0
               : err_last_q | (xfer & (io.s_last ^ (col_end && row == RW'(IMG_ROWS - 1))));
    row_hit = fed && col_end && row == RW'(state_q == FILL ? FILL_ROWS - 1
                                         : state_q == STREAM ? IMG_ROWS - 1 : ROWS - 1);
    state_d = state_q;
    if (start && !busy) state_d = CLR;
    else if (state_q == CLR) state_d = FILL;
    else if (row_hit) state_d = state_q == FILL ? STREAM : state_q == STREAM ? FLUSH : DONE;
  end
  always_ff @(posedge r_clk or posedge r_rst)
    if (r_rst) begin
      state_q <= IDLE;
      win_cnt_q <= '0;
      err_last_q <= 1'b0;
      fed_d1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_cnt_q <= win_cnt_d;
      err_last_q <= err_last_d;
      fed_d1_q <= fed_d1_d;
    end
endmodule

// File: tb/tb_window_feed_sequencer.sv
// tb_window_feed_sequencer: drives frames through the sequencer with a window generator model
// and checks every cycle against a pixel-count reference.
module tb_window_feed_sequencer;
  import dehaze_pkg::*;
  localparam int R = 8;
  localparam int I = 6;
  localparam int SRC = R * I;
  localparam int TOTAL = (I + 1) * R;
  localparam int FIRST = 3 * R;
  localparam int EXP = (I + 1 - 3) * R;

  logic r_clk, r_rst, start, busy, frame_done, err_last;
  window_feed_sequencer_if io();
  window_feed_sequencer #(.ROW_SIZE(R), .IMG_ROWS(I)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .start(start), .io(io.slave),
    .busy(busy), .frame_done(frame_done), .err_last(err_last)
  );

  int wg_n = 0;
  logic wg_ov = 1'b0;
  always @(posedge r_clk)
    if (io.wg_rst) begin
      wg_n <= 0;
      wg_ov <= 1'b0;
    end else if (io.wg_valid) begin
      wg_n <= wg_n + 1;
      wg_ov <= wg_n >= FIRST;
    end
  assign io.wg_out_valid = wg_ov;

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chkw(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_err_last"}, err_last, 1'b0);
    chk({tag, "_s_ready"}, io.s_ready, 1'b0);
    chk({tag, "_wg_valid"}, io.wg_valid, 1'b0);
    chk({tag, "_wg_rst"}, io.wg_rst, 1'b0);
    chk({tag, "_win_valid"}, io.win_valid, 1'b0);
    chkw({tag, "_wg_pixel"}, int'(io.wg_pixel), 0);
  endtask

  // mode 0: m_ready always high, 1: toggling, 2: random handshake plus stray starts
  task automatic frame(input int mode, input int last_at, input bit chain, input bit do_start);
    int k = 0, src = 0, prev_idx = -1, wins = 0;
    bit prev_fed = 1'b0, err = 1'b0, done_seen = 1'b0;
    bit m, v, sp, fp, ew, ed, ev;
    pixel_t px;
    if (do_start) begin
      tick();
      start = 1'b1; m_drive(1'b1, 1'b1); io.s_last = 1'b0;
      @(negedge r_clk);
      chk("pre_busy", busy, 1'b0);
      chk("pre_wg_valid", io.wg_valid, 1'b0);
    end
    tick();
    start = 1'b0;
    @(negedge r_clk);
    chk("clr_wg_rst", io.wg_rst, 1'b1);
    chk("clr_busy", busy, 1'b1);
    chk("clr_s_ready", io.s_ready, 1'b0);
    for (int c = 0; c < 2000 && !done_seen; c++) begin
      tick();
      m = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 0) : ($urandom_range(3) != 0);
      v = mode == 2 ? ($urandom_range(2) != 0) : 1'b1;
      px = pixel_t'($urandom);
      sp = k < SRC;
      fp = k >= SRC && k < TOTAL;
      ew = prev_fed && prev_idx >= FIRST;
      ed = ew && prev_idx == TOTAL - 1;
      ev = m && (sp ? v : fp);
      start = (chain && ed) || (mode == 2 && k < TOTAL && $urandom_range(7) == 0);
      m_drive(m, v);
      io.s_pixel = px;
      io.s_last = sp && src + 1 == last_at;
      @(negedge r_clk);
      chk("s_ready", io.s_ready, sp && m);
      chk("wg_valid", io.wg_valid, ev);
      if (ev) chkw("wg_pixel", int'(io.wg_pixel), sp ? int'(px) : 0);
      chk("win_valid", io.win_valid, ew);
      chk("frame_done", frame_done, ed);
      chk("busy", busy, k < TOTAL);
      chk("err_last", err_last, err);
      wins += int'(io.win_valid);
      if (sp && m && v) begin
        err |= io.s_last != (src == SRC - 1);
        src++;
      end
      if (ev) begin
        prev_idx = k;
        k++;
      end
      prev_fed = ev;
      done_seen = ed;
    end
    chk("frame_done_seen", done_seen, 1'b1);
    chkw("win_count", wins, EXP);
    chk("err_final", err_last, last_at != SRC);
  endtask

  task automatic m_drive(input bit m, input bit v);
    io.m_ready = m;
    io.s_valid = v;
  endtask

  typedef struct {
    bit start, m, v;
    bit busy, sr, wv, wr;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    r_rst = 1'b1;
    start = 1'b1;
    m_drive(1'b1, 1'b1);
    io.s_pixel = 24'hABCDEF;
    io.s_last = 1'b1;
    #12;
    all_zero("reset");
    @(negedge r_clk);
    r_rst = 1'b0;
    start = 1'b0;
    io.s_last = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      start = tbl[i].start;
      m_drive(tbl[i].m, tbl[i].v);
      io.s_pixel = pixel_t'($urandom);
      @(negedge r_clk);
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_s_ready", io.s_ready, tbl[i].sr);
      chk("tbl_wg_valid", io.wg_valid, tbl[i].wv);
      chk("tbl_wg_rst", io.wg_rst, tbl[i].wr);
    end
    tick();
    start = 1'b0;
    #2 r_rst = 1'b1;
    #1 chk("tbl_reset_busy", busy, 1'b0);
    @(negedge r_clk);
    r_rst = 1'b0;
    frame(0, SRC, 1'b1, 1'b1);
    frame(1, SRC, 1'b0, 1'b0);
    frame(0, 40, 1'b0, 1'b1);
    frame(0, SRC, 1'b0, 1'b1);
    frame(2, SRC, 1'b0, 1'b1);
    frame(2, 0, 1'b1, 1'b1);
    frame(2, SRC, 1'b0, 1'b0);
    tick();
    start = 1'b1;
    m_drive(1'b1, 1'b1);
    io.s_last = 1'b0;
    tick();
    start = 1'b0;
    repeat (20) begin
      tick();
      io.s_pixel = pixel_t'($urandom);
    end
    tick();
    io.s_pixel = 24'h123456;
    #2 r_rst = 1'b1;
    #1 all_zero("midrst");
    @(negedge r_clk);
    all_zero("midrst_hold");
    r_rst = 1'b0;
    frame(0, SRC, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
